// File: rtl/stack_pkg.sv
// Shared types for the stack-machine operand stack controller:
// opcodes, error codes and controller states.
package stack_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_PUSH  = 4'd1,
        OP_POP   = 4'd2,
        OP_DUP   = 4'd3,
        OP_SWAP  = 4'd4,
        OP_ADD   = 4'd5,
        OP_SUB   = 4'd6,
        OP_AND   = 4'd7,
        OP_OR    = 4'd8,
        OP_XOR   = 4'd9,
        OP_CLEAR = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNDER   = 2'd1,
        ERR_OVER    = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/response channel between the sequencer (master) and the
// stack controller (slave).
interface stack_ctrl_if import stack_pkg::*; #(parameter int DW = 8) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [DW-1:0] cmd_imm;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          err_valid;
    err_e          err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_imm,
        input  cmd_ready, out_valid, out_data, err_valid, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm,
        output cmd_ready, out_valid, out_data, err_valid, err_code
    );

endinterface

// File: rtl/stack_alu.sv
// Binary ALU for stack ops; a is NOS, b is TOS, results wrap mod 2**DW.
module stack_alu import stack_pkg::*; #(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result
);

    // Result selection by opcode
    always_comb begin
        result = {DW{1'b0}};
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/stack_ctrl.sv
// LIFO operand-stack controller driving a 2**AW x DW register file.
// RF writes and sp updates land on the accepting edge; SWAP takes two cycles.
module stack_ctrl import stack_pkg::*; #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    stack_ctrl_if.slave    cmd,
    output logic [AW:0]    depth,
    output logic [AW-1:0]  re_sel_a,
    output logic [AW-1:0]  re_sel_b,
    input  logic [DW-1:0]  re_data_a,
    input  logic [DW-1:0]  re_data_b,
    output logic [AW-1:0]  wr_sel,
    output logic [DW-1:0]  wr_data,
    output logic           wr_en
);

    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_TWO  = (AW+1)'(2);
    localparam logic [AW:0] SP_FULL = (AW+1)'(2**AW);

    logic [AW:0]   sp_r, sp_next_s, sp_m1_s, sp_m2_s;
    state_e        state_r, state_next_s;
    logic          cmd_ready_r;
    logic          out_valid_r, out_valid_next_s;
    logic [DW-1:0] out_data_r, out_data_next_s;
    logic          err_valid_r, err_valid_next_s;
    err_e          err_code_r, err_code_next_s;
    logic [DW-1:0] hold_r, hold_next_s;
    logic [DW-1:0] alu_result_s;
    logic          accept_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_sel_s;
    logic [DW-1:0] wr_data_s;

    assign sp_m1_s  = sp_r - SP_ONE;
    assign sp_m2_s  = sp_r - SP_TWO;
    assign re_sel_a = sp_m1_s[AW-1:0];
    assign re_sel_b = sp_m2_s[AW-1:0];
    assign accept_s = cmd.cmd_valid & cmd_ready_r;

    assign depth         = sp_r;
    assign cmd.cmd_ready = cmd_ready_r;
    assign cmd.out_valid = out_valid_r;
    assign cmd.out_data  = out_data_r;
    assign cmd.err_valid = err_valid_r;
    assign cmd.err_code  = err_code_r;

    // The RF write strobe must be quiet while reset is asserted, even mid-SWAP
    assign wr_en   = wr_en_s & reset_n;
    assign wr_sel  = wr_sel_s;
    assign wr_data = wr_data_s;

    stack_alu #(.DW(DW)) u_alu (
        .op     (cmd.cmd_op),
        .a      (re_data_b),
        .b      (re_data_a),
        .result (alu_result_s)
    );

    // Command decode: RF write port, next sp/state and response pulses
    always_comb begin
        sp_next_s        = sp_r;
        state_next_s     = state_r;
        wr_en_s          = 1'b0;
        wr_sel_s         = sp_r[AW-1:0];
        wr_data_s        = {DW{1'b0}};
        out_valid_next_s = 1'b0;
        out_data_next_s  = out_data_r;
        err_valid_next_s = 1'b0;
        err_code_next_s  = err_code_r;
        hold_next_s      = hold_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (cmd.cmd_op)
                        OP_NOP: begin
                        end
                        OP_PUSH: begin
                            if (sp_r == SP_FULL) begin
                                err_valid_next_s = 1'b1;
                                err_code_next_s  = ERR_OVER;
                            end else begin
                                wr_en_s     = 1'b1;
                                wr_data_s   = cmd.cmd_imm;
                                sp_next_s   = sp_r + SP_ONE;
                            end
                        end
                        OP_POP: begin
                            if (sp_r < SP_ONE) begin
                                err_valid_next_s = 1'b1;
                                err_code_next_s  = ERR_UNDER;
                            end else begin
                                out_valid_next_s = 1'b1;
                                out_data_next_s  = re_data_a;
                                sp_next_s        = sp_m1_s;
                            end
                        end
                        OP_DUP: begin
                            if (sp_r < SP_ONE) begin
                                err_valid_next_s = 1'b1;
                                err_code_next_s  = ERR_UNDER;
                            end else if (sp_r == SP_FULL) begin
                                err_valid_next_s = 1'b1;
                                err_code_next_s  = ERR_OVER;
                            end else begin
                                wr_en_s   = 1'b1;
                                wr_data_s = re_data_a;
                                sp_next_s = sp_r + SP_ONE;
                            end
                        end
                        OP_SWAP: begin
                            if (sp_r < SP_TWO) begin
                                err_valid_next_s = 1'b1;
                                err_code_next_s  = ERR_UNDER;
                            end else begin
                                wr_en_s      = 1'b1;
                                wr_sel_s     = sp_m1_s[AW-1:0];
                                wr_data_s    = re_data_b;
                                hold_next_s  = re_data_a;
                                state_next_s = SWAP2;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            if (sp_r < SP_TWO) begin
                                err_valid_next_s = 1'b1;
                                err_code_next_s  = ERR_UNDER;
                            end else begin
                                wr_en_s   = 1'b1;
                                wr_sel_s  = sp_m2_s[AW-1:0];
                                wr_data_s = alu_result_s;
                                sp_next_s = sp_m1_s;
                            end
                        end
                        OP_CLEAR: begin
                            sp_next_s = {(AW+1){1'b0}};
                        end
                        default: begin
                            err_valid_next_s = 1'b1;
                            err_code_next_s  = ERR_ILLEGAL;
                        end
                    endcase
                end else begin
                    sp_next_s = sp_r;
                end
            end
            SWAP2: begin
                wr_en_s      = 1'b1;
                wr_sel_s     = sp_m2_s[AW-1:0];
                wr_data_s    = hold_r;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Controller state and registered sequencer-facing outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_r        <= {(AW+1){1'b0}};
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            err_valid_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            hold_r      <= {DW{1'b0}};
        end else begin
            sp_r        <= sp_next_s;
            state_r     <= state_next_s;
            cmd_ready_r <= (state_next_s == IDLE);
            out_valid_r <= out_valid_next_s;
            out_data_r  <= out_data_next_s;
            err_valid_r <= err_valid_next_s;
            err_code_r  <= err_code_next_s;
            hold_r      <= hold_next_s;
        end
    end

endmodule
